// File: rtl/perf_counter_bank_if.sv
// Bus bundle for perf_counter_bank: event inputs, history read port and status outputs.
// The total_sel select exists only when PERF_CNT_TOTAL_EN is defined.
interface perf_counter_bank_if #(
  parameter int unsigned NUM_CNT = 8,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEPTH   = 32
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  logic               layer_done;
  logic [NUM_CNT-1:0] cnt_inc;
  logic               clear;
  logic               rd_req;
  logic [AW-1:0]      rd_layer;
  logic [CW-1:0]      rd_cnt;
  logic               rd_valid;
  logic [CNT_W-1:0]   rd_data;
  logic [AW:0]        layer_count;
  logic               full;
  logic [NUM_CNT-1:0] ovf;
  logic               dropped;
`ifdef PERF_CNT_TOTAL_EN
  logic               total_sel;
`endif

  modport master (
`ifdef PERF_CNT_TOTAL_EN
    output total_sel,
`endif
    output layer_done, cnt_inc, clear, rd_req, rd_layer, rd_cnt,
    input  rd_valid, rd_data, layer_count, full, ovf, dropped
  );

  modport slave (
`ifdef PERF_CNT_TOTAL_EN
    input  total_sel,
`endif
    input  layer_done, cnt_inc, clear, rd_req, rd_layer, rd_cnt,
    output rd_valid, rd_data, layer_count, full, ovf, dropped
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Per-layer performance counter bank: saturating live counters snapshotted into a history
// on each layer_done rising edge. Define PERF_CNT_TOTAL_EN for saturating grand totals.
module perf_counter_bank #(
  parameter int unsigned NUM_CNT = 8,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEPTH   = 32,
  parameter bit          WRAP    = 1'b0
) (
  input logic                clk,
  input logic                rst,
  perf_counter_bank_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [AW:0]      DepthCnt = (AW+1)'(DEPTH);

  logic               done_q, done_d, snap;
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]        layer_count_q, layer_count_d;
  logic               full_q, full_d;
  logic               dropped_q, dropped_d;
  logic [DEPTH-1:0]   ent_valid_q, ent_valid_d;
  logic               rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic [CNT_W-1:0]   rd_word;
  logic               mem_we;
  logic [CNT_W-1:0]   mem_q [DEPTH][NUM_CNT];

`ifdef PERF_CNT_TOTAL_EN
  localparam int unsigned TW = CNT_W + 16;
  logic [TW-1:0] tot_q [NUM_CNT];
  logic [TW-1:0] tot_d [NUM_CNT];
  logic [TW-1:0] tot_rd;
  logic [TW:0]   tot_sum;
`endif

  assign snap = bus.layer_done & ~done_q;

  // Read path samples the pre-write history, so a same-cycle snap returns old contents.
  always_comb begin
    rd_word = '0;
    if ((32'(bus.rd_cnt) < NUM_CNT) && ent_valid_q[bus.rd_layer]) begin
      rd_word = mem_q[bus.rd_layer][bus.rd_cnt];
    end
`ifdef PERF_CNT_TOTAL_EN
    tot_rd = '0;
    if (bus.total_sel && (bus.rd_layer == AW'(DEPTH - 1))) begin
      rd_word = '0;
      if (32'(bus.rd_cnt) < NUM_CNT) begin
        tot_rd  = tot_q[bus.rd_cnt];
        rd_word = (tot_rd[TW-1:CNT_W] != '0) ? CntMax : tot_rd[CNT_W-1:0];
      end
    end
`endif
  end

  always_comb begin
    done_d        = bus.layer_done;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    wr_ptr_d      = wr_ptr_q;
    layer_count_d = layer_count_q;
    full_d        = full_q;
    dropped_d     = dropped_q;
    ent_valid_d   = ent_valid_q;
    rd_valid_d    = 1'b0;
    rd_data_d     = rd_data_q;
    mem_we        = 1'b0;
    if (bus.clear) begin
      done_d        = 1'b0;
      cnt_d         = '{default: '0};
      ovf_d         = '0;
      wr_ptr_d      = '0;
      layer_count_d = '0;
      full_d        = 1'b0;
      dropped_d     = 1'b0;
      ent_valid_d   = '0;
      rd_data_d     = '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (snap) begin
          cnt_d[i] = CNT_W'(bus.cnt_inc[i]);
        end else if (bus.cnt_inc[i]) begin
          if (cnt_q[i] == CntMax) ovf_d[i] = 1'b1;
          else                    cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      if (snap) begin
        if (WRAP || !full_q) begin
          mem_we                = ~rst;
          ent_valid_d[wr_ptr_q] = 1'b1;
          wr_ptr_d              = wr_ptr_q + 1'b1;
        end else begin
          dropped_d = 1'b1;
        end
        if (layer_count_q != DepthCnt) layer_count_d = layer_count_q + 1'b1;
        full_d = full_q | (layer_count_d == DepthCnt);
      end
      rd_valid_d = bus.rd_req;
      if (bus.rd_req) rd_data_d = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q        <= 1'b0;
      cnt_q         <= '{default: '0};
      ovf_q         <= '0;
      wr_ptr_q      <= '0;
      layer_count_q <= '0;
      full_q        <= 1'b0;
      dropped_q     <= 1'b0;
      ent_valid_q   <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      done_q        <= done_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      wr_ptr_q      <= wr_ptr_d;
      layer_count_q <= layer_count_d;
      full_q        <= full_d;
      dropped_q     <= dropped_d;
      ent_valid_q   <= ent_valid_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // History storage is never reset; per-entry valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NUM_CNT; i++) mem_q[wr_ptr_q][i] <= cnt_q[i];
    end
  end

`ifdef PERF_CNT_TOTAL_EN
  // Totals accumulate every snap, including ones whose history write is dropped.
  always_comb begin
    tot_d   = tot_q;
    tot_sum = '0;
    if (bus.clear) begin
      tot_d = '{default: '0};
    end else if (snap) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        tot_sum  = {1'b0, tot_q[i]} + (TW+1)'(cnt_q[i]);
        tot_d[i] = tot_sum[TW] ? '1 : tot_sum[TW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tot_q <= '{default: '0};
    else     tot_q <= tot_d;
  end
`endif

  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.layer_count = layer_count_q;
  assign bus.full        = full_q;
  assign bus.ovf         = ovf_q;
  assign bus.dropped     = dropped_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a stop-when-full and a ring instance share stimulus and are
// compared against a layer-level reference model of event counts and stored snapshots.
module tb_perf_counter_bank;
  localparam int unsigned NC   = 6;
  localparam int unsigned DP   = 4;
  localparam int unsigned MAXV = 255;

  typedef logic [19:0] st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, layer_done, clear, rd_req;
  logic [NC-1:0] cnt_inc;
  logic [1:0]    rd_layer;
  logic [2:0]    rd_cnt;

  perf_counter_bank_if #(.NUM_CNT(NC), .CNT_W(8), .DEPTH(DP)) bus_a ();
  perf_counter_bank_if #(.NUM_CNT(NC), .CNT_W(8), .DEPTH(DP)) bus_b ();

  assign bus_a.layer_done = layer_done;
  assign bus_a.cnt_inc    = cnt_inc;
  assign bus_a.clear      = clear;
  assign bus_a.rd_req     = rd_req;
  assign bus_a.rd_layer   = rd_layer;
  assign bus_a.rd_cnt     = rd_cnt;
  assign bus_b.layer_done = layer_done;
  assign bus_b.cnt_inc    = cnt_inc;
  assign bus_b.clear      = clear;
  assign bus_b.rd_req     = rd_req;
  assign bus_b.rd_layer   = rd_layer;
  assign bus_b.rd_cnt     = rd_cnt;
`ifdef PERF_CNT_TOTAL_EN
  assign bus_a.total_sel  = 1'b0;
  assign bus_b.total_sel  = 1'b0;
`endif

  perf_counter_bank #(.NUM_CNT(NC), .CNT_W(8), .DEPTH(DP), .WRAP(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  perf_counter_bank #(.NUM_CNT(NC), .CNT_W(8), .DEPTH(DP), .WRAP(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: raw event counts per layer, history as a list of saturated snapshots.
  int unsigned   raw [NC];
  logic [NC-1:0] m_ovf;
  int unsigned   hist_a [DP][NC];
  int unsigned   hist_b [DP][NC];
  logic [DP-1:0] hv_a, hv_b;
  int unsigned   n_snaps;
  logic          prev_done;
  logic          m_rv;
  int unsigned   m_rd_a, m_rd_b;

  function automatic int unsigned sat(input int unsigned v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_step();
    if (rst || clear) begin
      for (int i = 0; i < NC; i++) raw[i] = 0;
      m_ovf = '0; n_snaps = 0; hv_a = '0; hv_b = '0;
      m_rv = 1'b0; prev_done = 1'b0;
      m_rd_a = 0; m_rd_b = 0;
      return;
    end
    m_rv = rd_req;
    if (rd_req) begin
      m_rd_a = (rd_cnt < NC && hv_a[rd_layer]) ? hist_a[rd_layer][rd_cnt] : 0;
      m_rd_b = (rd_cnt < NC && hv_b[rd_layer]) ? hist_b[rd_layer][rd_cnt] : 0;
    end
    if (layer_done && !prev_done) begin
      for (int i = 0; i < NC; i++) begin
        if (n_snaps < DP) hist_a[n_snaps][i] = sat(raw[i]);
        hist_b[n_snaps % DP][i] = sat(raw[i]);
        raw[i] = cnt_inc[i];
      end
      if (n_snaps < DP) hv_a[n_snaps] = 1'b1;
      hv_b[n_snaps % DP] = 1'b1;
      n_snaps++;
    end else begin
      for (int i = 0; i < NC; i++) raw[i] += cnt_inc[i];
    end
    for (int i = 0; i < NC; i++) if (raw[i] > MAXV) m_ovf[i] = 1'b1;
    prev_done = layer_done;
  endtask

  function automatic st_t exp_st(input bit wrap);
    int unsigned lc = (n_snaps > DP) ? DP : n_snaps;
    return {m_rv, wrap ? 8'(m_rd_b) : 8'(m_rd_a), 3'(lc), (n_snaps >= DP), m_ovf,
            (!wrap && n_snaps > DP)};
  endfunction

  function automatic st_t act_st(input bit wrap);
    if (wrap) return {bus_b.rd_valid, bus_b.rd_data, bus_b.layer_count, bus_b.full,
                      bus_b.ovf, bus_b.dropped};
    return {bus_a.rd_valid, bus_a.rd_data, bus_a.layer_count, bus_a.full,
            bus_a.ovf, bus_a.dropped};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    layer_done = 1'b0; clear = 1'b0; rd_req = 1'b0;
    cnt_inc = '0; rd_layer = '0; rd_cnt = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic do_snap(input logic [NC-1:0] inc);
    layer_done = 1'b1; cnt_inc = inc; tick();
    layer_done = 1'b0; cnt_inc = '0; tick();
  endtask

  task automatic do_read(input int l, input int c);
    rd_req = 1'b1; rd_layer = 2'(l); rd_cnt = 3'(c); tick(); rd_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (act_st(0) !== '0) begin
      errors++; $display("FAIL reset_a: got %h expected 0", act_st(0));
    end
    checks++;
    if (act_st(1) !== '0) begin
      errors++; $display("FAIL reset_b: got %h expected 0", act_st(1));
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    for (int c = 0; c < 100; c++) begin
      cnt_inc = {3'b000, 1'b1, (c % 2 == 0), 1'b1};
      tick();
    end
    layer_done = 1'b1; cnt_inc = 6'b000100; tick();
    layer_done = 1'b0;
    checks++;
    if (bus_a.layer_count !== 3'd1) begin
      errors++; $display("FAIL basic_layer_count: got %0d expected 1", bus_a.layer_count);
    end
    repeat (20) tick();
    cnt_inc = '0;
    layer_done = 1'b1; tick(); layer_done = 1'b0;
    do_read(0, 0);
    checks++;
    if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 8'd100) begin
      errors++; $display("FAIL basic_cnt0: got v=%b d=%0d expected v=1 d=100",
                         bus_a.rd_valid, bus_a.rd_data);
    end
    tick();
    checks++;
    if (bus_a.rd_valid !== 1'b0 || bus_a.rd_data !== 8'd100) begin
      errors++; $display("FAIL basic_valid_pulse: got v=%b d=%0d expected v=0 d=100",
                         bus_a.rd_valid, bus_a.rd_data);
    end
    do_read(0, 1);
    checks++;
    if (bus_a.rd_data !== 8'd50) begin
      errors++; $display("FAIL basic_cnt1: got %0d expected 50", bus_a.rd_data);
    end
    do_read(0, 2);
    checks++;
    if (bus_b.rd_data !== 8'd100) begin
      errors++; $display("FAIL basic_cnt2_l0: got %0d expected 100", bus_b.rd_data);
    end
    do_read(1, 2);
    checks++;
    if (bus_a.rd_data !== 8'd21 || act_st(0) !== exp_st(0)) begin
      errors++; $display("FAIL basic_cnt2_l1: got %0d expected 21", bus_a.rd_data);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    cnt_inc = 6'b001000;
    repeat (300) tick();
    cnt_inc = '0;
    checks++;
    if (bus_a.ovf !== 6'b001000 || bus_b.ovf !== 6'b001000) begin
      errors++; $display("FAIL sat_ovf: got %b/%b expected 001000", bus_a.ovf, bus_b.ovf);
    end
    do_snap('0);
    do_read(0, 3);
    checks++;
    if (bus_a.rd_data !== 8'd255 || bus_a.ovf !== 6'b001000) begin
      errors++; $display("FAIL sat_value: got %0d ovf=%b expected 255 ovf=001000",
                         bus_a.rd_data, bus_a.ovf);
    end
  endtask

  task automatic test_full_wrap();
    do_clear();
    for (int s = 0; s < 6; s++) begin
      repeat ($urandom_range(3, 12)) begin
        cnt_inc = NC'($urandom);
        tick();
      end
      do_snap(NC'($urandom));
    end
    checks++;
    if (act_st(0) !== exp_st(0) || bus_a.full !== 1'b1 || bus_a.dropped !== 1'b1 ||
        bus_a.layer_count !== 3'd4) begin
      errors++; $display("FAIL full_stop: got %h expected %h", act_st(0), exp_st(0));
    end
    checks++;
    if (act_st(1) !== exp_st(1) || bus_b.full !== 1'b1 || bus_b.dropped !== 1'b0 ||
        bus_b.layer_count !== 3'd4) begin
      errors++; $display("FAIL full_ring: got %h expected %h", act_st(1), exp_st(1));
    end
    for (int l = 0; l < DP; l++) begin
      for (int c = 0; c < NC; c++) begin
        do_read(l, c);
        checks++;
        if (bus_a.rd_data !== 8'(m_rd_a) || bus_b.rd_data !== 8'(m_rd_b)) begin
          errors++; $display("FAIL hist_l%0d_c%0d: got %0d/%0d expected %0d/%0d", l, c,
                             bus_a.rd_data, bus_b.rd_data, m_rd_a, m_rd_b);
        end
      end
    end
  endtask

  task automatic test_level_and_clear();
    do_clear();
    layer_done = 1'b1;
    repeat (10) tick();
    layer_done = 1'b0; tick();
    checks++;
    if (bus_a.layer_count !== 3'd1 || bus_b.layer_count !== 3'd1) begin
      errors++; $display("FAIL level_once: got %0d/%0d expected 1",
                         bus_a.layer_count, bus_b.layer_count);
    end
    cnt_inc = 6'b111111; repeat (5) tick(); cnt_inc = '0;
    layer_done = 1'b1; clear = 1'b1; tick();
    layer_done = 1'b0; clear = 1'b0; tick();
    checks++;
    if (bus_a.layer_count !== 3'd0 || bus_b.layer_count !== 3'd0) begin
      errors++; $display("FAIL clear_snap_count: got %0d/%0d expected 0",
                         bus_a.layer_count, bus_b.layer_count);
    end
    do_read(0, 0);
    checks++;
    if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 8'd0 || bus_b.rd_data !== 8'd0) begin
      errors++; $display("FAIL clear_snap_read: got v=%b %0d/%0d expected v=1 0/0",
                         bus_a.rd_valid, bus_a.rd_data, bus_b.rd_data);
    end
  endtask

  task automatic test_same_entry();
    do_clear();
    for (int s = 0; s < DP; s++) begin
      cnt_inc = 6'b000001; repeat (s + 3) tick();
      do_snap('0);
    end
    cnt_inc = 6'b000001; repeat (9) tick();
    layer_done = 1'b1; cnt_inc = '0;
    do_read(0, 0);
    layer_done = 1'b0;
    checks++;
    if (bus_b.rd_data !== 8'd3 || bus_b.rd_data !== 8'(m_rd_b)) begin
      errors++; $display("FAIL same_entry_old: got %0d expected 3", bus_b.rd_data);
    end
    do_read(0, 0);
    checks++;
    if (bus_b.rd_data !== 8'd9 || bus_a.rd_data !== 8'd3) begin
      errors++; $display("FAIL same_entry_new: got %0d/%0d expected 3/9",
                         bus_a.rd_data, bus_b.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    rd_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rd_layer = 2'(k % DP); rd_cnt = 3'(k);
      tick();
      checks++;
      if (act_st(0) !== exp_st(0) || act_st(1) !== exp_st(1)) begin
        errors++; $display("FAIL b2b_%0d: got %h/%h expected %h/%h", k,
                           act_st(0), act_st(1), exp_st(0), exp_st(1));
      end
    end
    rd_req = 1'b0; tick();
    checks++;
    if (bus_a.rd_valid !== 1'b0 || bus_b.rd_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got %b/%b expected 0/0", bus_a.rd_valid, bus_b.rd_valid);
    end
  endtask

  task automatic test_rst_mid();
    cnt_inc = 6'b111111; repeat (15) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (act_st(0) !== '0 || act_st(1) !== '0) begin
      errors++; $display("FAIL rst_mid: got %h/%h expected 0", act_st(0), act_st(1));
    end
    cnt_inc = 6'b000001; repeat (7) tick();
    do_snap('0);
    do_read(0, 0);
    checks++;
    if (bus_a.rd_data !== 8'd7 || bus_b.rd_data !== 8'd7) begin
      errors++; $display("FAIL rst_post_snap: got %0d/%0d expected 7",
                         bus_a.rd_data, bus_b.rd_data);
    end
  endtask

  task automatic test_random();
    do_clear();
    for (int n = 0; n < 800; n++) begin
      cnt_inc    = NC'($urandom);
      if ($urandom_range(0, 7) == 0) layer_done = ~layer_done;
      clear      = ($urandom_range(0, 149) == 0);
      rd_req     = $urandom_range(0, 1) == 1;
      rd_layer   = 2'($urandom);
      rd_cnt     = 3'($urandom);
      tick();
      checks++;
      if (act_st(0) !== exp_st(0)) begin
        errors++; $display("FAIL rand_a_%0d: got %h expected %h", n, act_st(0), exp_st(0));
      end
      checks++;
      if (act_st(1) !== exp_st(1)) begin
        errors++; $display("FAIL rand_b_%0d: got %h expected %h", n, act_st(1), exp_st(1));
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_saturation();
    test_full_wrap();
    test_level_and_clear();
    test_same_entry();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
